// File: rtl/pulse_sequencer.sv
// Three-pulse NMR timing engine: LEAD, P1, D1, P2, D2, P3, DEAD, ACQ driven by snapshotted timing words.
// Optional repeat mode (WAIT state, rep_delay_i) is enabled by defining PULSE_SEQ_REPEAT_EN.
module pulse_sequencer #(
  parameter int CNT_W       = 32,
  parameter int AMP_LEAD    = 20,
  parameter int DEAD_CYCLES = 40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable_PC,
  input  logic [6*CNT_W-1:0] pulse_timing_data,
  input  logic [14:0]        TX_phase_data,
`ifdef PULSE_SEQ_REPEAT_EN
  input  logic [CNT_W-1:0]   rep_delay_i,
`endif
  output logic               rf_gate_o,
  output logic [4:0]         phase_sel_o,
  output logic               amp_enable_o,
  output logic               adc_enable_o,
  output logic               busy_o,
  output logic               seq_done_o
);

  // Running states double as the stage index 0..7 so zero-length skipping is a simple search.
  typedef enum logic [3:0] {
    LEAD = 4'd0, PULSE1 = 4'd1, DELAY1 = 4'd2, PULSE2 = 4'd3, DELAY2 = 4'd4,
    PULSE3 = 4'd5, DEAD = 4'd6, ACQ = 4'd7, IDLE = 4'd8, ARMED = 4'd9, WAIT = 4'd10
  } state_t;

  typedef logic [7:0][CNT_W-1:0] lens_t;

  function automatic lens_t make_lens(input logic [6*CNT_W-1:0] f);
    lens_t l;
    l[0] = CNT_W'(AMP_LEAD);
    for (int i = 1; i <= 5; i++) l[i] = f[(6-i)*CNT_W +: CNT_W];
    l[6] = CNT_W'(DEAD_CYCLES);
    l[7] = f[CNT_W-1:0];
    return l;
  endfunction

  // First stage at or after 'from' with a non-zero length; 8 means the sequence is over.
  function automatic logic [3:0] first_stage(input lens_t l, input logic [3:0] from);
    logic [3:0] r;
    r = 4'd8;
    for (int i = 7; i >= 0; i--)
      if (i >= int'(from) && l[i] != '0) r = 4'(i);
    return r;
  endfunction

  state_t             state, nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [6*CNT_W-1:0] snap_f;
  logic [14:0]        snap_ph;
  logic               load, fin, start, done_d;
  logic [3:0]         k;
  lens_t              cur_l, new_l;

  assign cur_l = make_lens(snap_f);
  assign new_l = make_lens(pulse_timing_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      snap_f  <= '0;
      snap_ph <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (load) begin
        snap_f  <= pulse_timing_data;
        snap_ph <= TX_phase_data;
      end
    end
  end

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    load    = 1'b0;
    fin     = 1'b0;
    start   = 1'b0;
    done_d  = 1'b0;
    k       = 4'd8;
    case (state)
      IDLE:  if (!enable_PC) nxt = ARMED;
      ARMED: if (enable_PC) start = 1'b1;
      WAIT: begin
        if (!enable_PC)    nxt = IDLE;
        else if (cnt == '0) start = 1'b1;
        else               cnt_nxt = cnt - 1'b1;
      end
      default: begin
        if (!enable_PC)          nxt = IDLE;
        else if (cnt != '0)      cnt_nxt = cnt - 1'b1;
        else begin
          k = first_stage(cur_l, {1'b0, state[2:0]} + 4'd1);
          if (k[3]) fin = 1'b1;
          else begin
            nxt     = state_t'(k);
            cnt_nxt = cur_l[k[2:0]] - 1'b1;
          end
        end
      end
    endcase
    if (fin) begin
      done_d = 1'b1;
`ifdef PULSE_SEQ_REPEAT_EN
      if (rep_delay_i == '0) start = 1'b1;
      else begin
        nxt     = WAIT;
        cnt_nxt = rep_delay_i - 1'b1;
      end
`else
      nxt = IDLE;
`endif
    end
    if (start) begin
      load = 1'b1;
      k    = first_stage(new_l, 4'd0);
      if (k[3]) begin
        nxt    = IDLE;
        done_d = 1'b1;
      end else begin
        nxt     = state_t'(k);
        cnt_nxt = new_l[k[2:0]] - 1'b1;
      end
    end
  end

  // Outputs are decoded from the next state so each register shows the state it belongs to.
  logic        run_nxt, rf_d, amp_d, adc_d, busy_d;
  logic [2:0]  stg;
  logic [4:0]  ph_d;
  logic [14:0] ph_src;

  always_comb begin
    ph_src  = load ? TX_phase_data : snap_ph;
    run_nxt = !nxt[3];
    stg     = nxt[2:0];
    rf_d    = run_nxt && stg[0] && (stg <= 3'd5);
    amp_d   = run_nxt && (stg <= 3'd5);
    adc_d   = run_nxt && (stg == 3'd7);
    busy_d  = (nxt != IDLE) && (nxt != ARMED);
    ph_d    = phase_sel_o;
    if (amp_d) begin
      case (stg[2:1])
        2'd0:    ph_d = ph_src[14:10];
        2'd1:    ph_d = ph_src[9:5];
        default: ph_d = ph_src[4:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_gate_o    <= 1'b0;
      phase_sel_o  <= '0;
      amp_enable_o <= 1'b0;
      adc_enable_o <= 1'b0;
      busy_o       <= 1'b0;
      seq_done_o   <= 1'b0;
    end else begin
      rf_gate_o    <= rf_d;
      phase_sel_o  <= ph_d;
      amp_enable_o <= amp_d;
      adc_enable_o <= adc_d;
      busy_o       <= busy_d;
      seq_done_o   <= done_d;
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Randomized bench for pulse_sequencer: a segment-timeline reference model predicts every output per cycle.
module tb_pulse_sequencer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable_PC;
  logic [191:0] pulse_timing_data;
  logic [14:0]  TX_phase_data;
  logic         rf_gate_o, amp_enable_o, adc_enable_o, busy_o, seq_done_o;
  logic [4:0]   phase_sel_o;
`ifdef PULSE_SEQ_REPEAT_EN
  logic [31:0]  rep_delay_i = '0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pulse_sequencer dut (
    .clk(clk), .rst_n(rst_n), .enable_PC(enable_PC),
    .pulse_timing_data(pulse_timing_data), .TX_phase_data(TX_phase_data),
`ifdef PULSE_SEQ_REPEAT_EN
    .rep_delay_i(rep_delay_i),
`endif
    .rf_gate_o(rf_gate_o), .phase_sel_o(phase_sel_o), .amp_enable_o(amp_enable_o),
    .adc_enable_o(adc_enable_o), .busy_o(busy_o), .seq_done_o(seq_done_o)
  );

  always #5 clk = ~clk;

  // Reference timeline: segment lengths in play order and which phase each one shows.
  longint     m_len [8];
  logic [4:0] m_ph  [3];
  longint     m_abort;
  int         PIDX  [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
  logic [9:0] lg    [0:255];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] obs_vec();
    return {rf_gate_o, amp_enable_o, adc_enable_o, busy_o, seq_done_o, phase_sel_o};
  endfunction

  // Expected {rf,amp,adc,busy,done,phase} in cycle k (cycle 0 = enable sampled high).
  function automatic logic [9:0] model_at(input longint k);
    longint     kk, t;
    logic [4:0] ph;
    logic [9:0] r;
    bit         found;
    kk = (m_abort >= 0 && k > m_abort) ? m_abort : k;
    t = 1; ph = 5'd0; r = '0; found = 0;
    for (int i = 0; i < 8; i++) begin
      if (!found) begin
        if (kk >= t && kk < t + m_len[i]) begin
          if (i <= 5) ph = m_ph[PIDX[i]];
          r = {(i == 1 || i == 3 || i == 5), (i <= 5), (i == 7), 1'b1, 1'b0, ph};
          found = 1;
        end else begin
          if (i <= 5 && m_len[i] != 0) ph = m_ph[PIDX[i]];
          t += m_len[i];
        end
      end
    end
    if (!found) r = {4'b0, (kk == t), ph};
    if (k > kk) r = {5'b0, r[4:0]};
    return r;
  endfunction

  task automatic run_seq(input logic [191:0] f, input logic [14:0] ph,
                         input int abort_at, input int rst_at, input bit garble);
    longint t_done, last;
    m_len[0] = 20;
    for (int i = 1; i <= 5; i++) m_len[i] = longint'(f[(6-i)*32 +: 32]);
    m_len[6] = 40;
    m_len[7] = longint'(f[31:0]);
    m_ph[0] = ph[14:10]; m_ph[1] = ph[9:5]; m_ph[2] = ph[4:0];
    m_abort = (abort_at > 0) ? longint'(abort_at) : -1;
    t_done = 1;
    for (int i = 0; i < 8; i++) t_done += m_len[i];
    last = (abort_at > 0 && abort_at < t_done) ? longint'(abort_at) + 1 : t_done;
    if (rst_at > 0) last = rst_at;
    for (int i = 0; i < 256; i++) lg[i] = '0;
    enable_PC = 1'b0;
    step();
    step();
    pulse_timing_data = f;
    TX_phase_data     = ph;
    enable_PC         = 1'b1;
    for (longint k = 1; k <= last + 3; k++) begin
      step();
      chk($sformatf("cyc%0d", k), 32'(obs_vec()), 32'(model_at(k)));
      if (k < 256) lg[k] = obs_vec();
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_async", 32'(obs_vec()), 32'd0);
        enable_PC = 1'b0;
        step();
        rst_n = 1'b1;
        return;
      end
      if (garble) begin
        pulse_timing_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        TX_phase_data     = 15'($urandom);
      end
      if (k == abort_at) enable_PC = 1'b0;
    end
  endtask

  function automatic logic [31:0] rfield(input int maxv);
    return ($urandom_range(0, 9) < 3) ? 32'd0 : 32'($urandom_range(1, maxv));
  endfunction

  logic [191:0] nom;
  logic [14:0]  nph;
  int           cnt_hi;

  initial begin
    rst_n = 1'b0; enable_PC = 1'b0; pulse_timing_data = '0; TX_phase_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", 32'(obs_vec()), 32'd0);
    rst_n = 1'b1;

    nom = {32'd10, 32'd5, 32'd20, 32'd5, 32'd10, 32'd100};
    nph = {5'd3, 5'd7, 5'd12};

    // nominal run with register writes scrambled after the start
    run_seq(nom, nph, 0, 0, 1);
    chk("t1_rf20", 32'(lg[20][9]), 32'd0);
    chk("t1_rf21", 32'(lg[21][9]), 32'd1);
    chk("t1_rf31", 32'(lg[31][9]), 32'd0);
    chk("t1_rf36", 32'(lg[36][9]), 32'd1);
    chk("t1_rf70", 32'(lg[70][9]), 32'd1);
    chk("t1_amp1", 32'(lg[1][8]), 32'd1);
    chk("t1_adc111", 32'(lg[111][7]), 32'd1);
    chk("t1_adc211", 32'(lg[211][7]), 32'd0);
    chk("t1_done211", 32'(lg[211][5]), 32'd1);
    chk("t2_ph21", 32'(lg[21][4:0]), 32'd3);
    chk("t2_ph31", 32'(lg[31][4:0]), 32'd7);
    chk("t2_ph56", 32'(lg[56][4:0]), 32'd12);

    // zero-length fields
    run_seq({32'd10, 32'd0, 32'd0, 32'd5, 32'd10, 32'd0}, nph, 0, 0, 0);
    cnt_hi = 0;
    for (int i = 0; i < 256; i++) cnt_hi += int'(lg[i][7]);
    chk("t3_adc_never", 32'(cnt_hi), 32'd0);
    chk("t3_done86", 32'(lg[86][5]), 32'd1);
    chk("t3_gap35", 32'(lg[35][9]), 32'd0);
    chk("t3_p3_36", 32'(lg[36][9]), 32'd1);

    // abort mid PULSE2
    run_seq(nom, nph, 40, 0, 0);
    chk("t4_gates41", 32'(lg[41][9:5]), 32'd0);
    cnt_hi = 0;
    for (int i = 0; i < 256; i++) cnt_hi += int'(lg[i][5]);
    chk("t4_no_done", 32'(cnt_hi), 32'd0);

    // restart after abort, then async reset mid-run
    run_seq(nom, nph, 0, 0, 1);
    run_seq(nom, nph, 0, 50, 0);

    // maximum-length fields never wrap; aborted partway
    run_seq({6{32'hFFFF_FFFF}}, 15'h7FFF, 150, 0, 1);

    for (int r = 0; r < 25; r++) begin
      logic [191:0] f;
      int           ab;
      f  = {rfield(12), rfield(12), rfield(12), rfield(12), rfield(12), rfield(30)};
      ab = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 200) : 0;
      run_seq(f, 15'($urandom), ab, 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
